// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and counter sizing for shift blocks.
package shift_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/shift_xcvr_bit_counter.sv
// bit_counter: frame bit counter with synchronous clear, saturating at WIDTH-1.
module bit_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    assign last = count == LAST;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en && !last)
            count <= count + 1'b1;
endmodule

// File: rtl/shift_xcvr.sv
// shift_xcvr: full-duplex framed shift transceiver with valid/ready on both
// parallel sides and selectable bit order.
module shift_xcvr
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shifted;
    logic             load, strobe, last, finish;

    assign in_ready  = state == ST_IDLE || (state == ST_DONE && out_ready);
    assign load      = in_valid && in_ready;
    assign strobe    = state == ST_SHIFT && shift_en;
    assign finish    = strobe && last;
    assign busy      = state == ST_SHIFT;
    assign out_valid = state == ST_DONE;
    assign shifted   = MSB_FIRST ? {shift_reg[WIDTH-2:0], serial_in}
                                 : {serial_in, shift_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;

    // Load takes priority so DONE can hand straight over to the next frame.
    always_comb begin
        state_nxt = state;
        state_nxt = load ? ST_SHIFT
                  : finish ? ST_DONE
                  : (state == ST_DONE && out_ready) ? ST_IDLE
                  : state;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shift_reg  <= '0;
            serial_out <= 1'b0;
            out_data   <= '0;
        end else if (load) begin
            shift_reg  <= in_data;
            serial_out <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
        end else if (strobe) begin
            shift_reg  <= shifted;
            serial_out <= finish ? 1'b0 : (MSB_FIRST ? shift_reg[WIDTH-2] : shift_reg[1]);
            if (finish)
                out_data <= shifted;
        end

    bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (load),
        .en    (strobe),
        .last  (last)
    );
endmodule

// File: tb/tb_shift_xcvr.sv
// tb_shift_xcvr: directed bench for both bit orders against a positional frame model.
module tb_shift_xcvr;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       shift_en = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sin = 1'b0, loop = 1'b0;
    logic [7:0] in_data = '0;
    logic       so_a[2], ov_a[2], ir_a[2], busy_a[2], sin_a[2];
    logic [7:0] od_a[2];
    int         checks = 0, errors = 0;

    // Model: frame word, bit index, captured bits placed by position.
    int         st[2], k[2];
    logic       so[2];
    logic [7:0] od[2], cap[2], word[2];
    logic       so_m[9], so_l[9];
    logic       ov_pre;

    always #5 clk = ~clk;

    assign sin_a[0] = loop ? so_a[0] : sin;
    assign sin_a[1] = loop ? so_a[1] : sin;

    shift_xcvr #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .shift_en(shift_en), .in_valid(in_valid), .in_ready(ir_a[0]),
        .in_data(in_data), .serial_in(sin_a[0]), .serial_out(so_a[0]), .out_valid(ov_a[0]),
        .out_ready(out_ready), .out_data(od_a[0]), .busy(busy_a[0])
    );
    shift_xcvr #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .shift_en(shift_en), .in_valid(in_valid), .in_ready(ir_a[1]),
        .in_data(in_data), .serial_in(sin_a[1]), .serial_out(so_a[1]), .out_valid(ov_a[1]),
        .out_ready(out_ready), .out_data(od_a[1]), .busy(busy_a[1])
    );

    function automatic logic bit_at(input logic [7:0] w, input int i, input int d);
        return d == 0 ? w[7-i] : w[i];
    endfunction

    task automatic chk(input string n, input int d, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t actual=%h required=%h", n, d, $time, a, e);
        end
    endtask

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] nc;
        logic       b;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                st[d] <= 0; k[d] <= 0; so[d] <= 1'b0; od[d] <= '0; cap[d] <= '0; word[d] <= '0;
            end else if (in_valid && (st[d] == 0 || (st[d] == 2 && out_ready))) begin
                word[d] <= in_data; k[d] <= 0; st[d] <= 1; cap[d] <= '0;
                so[d] <= bit_at(in_data, 0, d);
            end else if (st[d] == 1 && shift_en) begin
                b = loop ? so[d] : sin;
                nc = cap[d];
                nc[d == 0 ? 7 - k[d] : k[d]] = b;
                cap[d] <= nc;
                if (k[d] == 7) begin
                    st[d] <= 2; od[d] <= nc; so[d] <= 1'b0;
                end else begin
                    k[d] <= k[d] + 1;
                    so[d] <= bit_at(word[d], k[d] + 1, d);
                end
            end else if (st[d] == 2 && out_ready)
                st[d] <= 0;
        end
    end

    always @(negedge clk)
        for (int d = 0; d < 2; d++) begin
            chk("serial_out", d, so_a[d], so[d]);
            chk("out_valid", d, ov_a[d], st[d] == 2);
            chk("busy", d, busy_a[d], st[d] == 1);
            chk("in_ready", d, ir_a[d], st[d] == 0 || (st[d] == 2 && out_ready));
            chk("out_data", d, od_a[d], od[d]);
        end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [7:0] d, input logic lp, input logic [7:0] pat, input int per);
        in_data = d; in_valid = 1'b1; loop = lp; shift_en = 1'b0; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        so_m[0] = so_a[0]; so_l[0] = so_a[1];
        for (int j = 0; j < 8; j++) begin
            for (int p = 1; p < per; p++) begin
                shift_en = 1'b0;
                tick;
            end
            if (j == 7) ov_pre = ov_a[0];
            sin = pat[7-j]; shift_en = 1'b1;
            tick;
            so_m[j+1] = so_a[0]; so_l[j+1] = so_a[1];
        end
        shift_en = 1'b0;
    endtask

    task automatic drain;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] e;
        tick; tick;
        rst = 1'b0;
        tick;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", d, ir_a[d], 1);
            chk("rst_out_valid", d, ov_a[d], 0);
            chk("rst_serial_out", d, so_a[d], 0);
            chk("rst_out_data", d, od_a[d], 8'h00);
            chk("rst_busy", d, busy_a[d], 0);
        end
        // asynchronous reset three strobes into a frame
        in_data = 8'hF0; loop = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; shift_en = 1'b1;
        repeat (3) tick;
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 0, busy_a[0], 0);
        chk("arst_serial_out", 0, so_a[0], 0);
        chk("arst_out_valid", 0, ov_a[0], 0);
        chk("arst_in_ready", 0, ir_a[0], 1);
        shift_en = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        frame(8'h5A, 1'b1, 8'h00, 1);
        chk("lb_5a", 0, od_a[0], 8'h5A);
        chk("lb_5a", 1, od_a[1], 8'h5A);
        drain;
        frame(8'hA5, 1'b1, 8'h00, 1);
        e = 8'hA5;
        for (int j = 0; j < 8; j++) chk("a5_bit", j, so_m[j], e[7-j]);
        chk("a5_tail", 0, so_m[8], 0);
        chk("a5_ov", 0, ov_a[0], 1);
        chk("a5_data", 0, od_a[0], 8'hA5);
        chk("a5_data", 1, od_a[1], 8'hA5);
        drain;
        frame(8'hFF, 1'b0, 8'h00, 1);
        for (int j = 0; j < 8; j++) chk("ff_bit", j, so_m[j], 1);
        chk("cap_00", 0, od_a[0], 8'h00);
        chk("cap_00", 1, od_a[1], 8'h00);
        drain;
        frame(8'h00, 1'b0, 8'hFF, 1);
        chk("cap_ff", 0, od_a[0], 8'hFF);
        chk("cap_ff", 1, od_a[1], 8'hFF);
        drain;
        frame(8'h01, 1'b0, 8'h00, 1);
        chk("lsb01_bit", 0, so_l[0], 1);
        for (int j = 1; j < 8; j++) chk("lsb01_bit", j, so_l[j], 0);
        drain;
        frame(8'h3C, 1'b1, 8'h00, 1);
        chk("lb_3c", 0, od_a[0], 8'h3C);
        chk("lb_3c", 1, od_a[1], 8'h3C);
        drain;
        frame(8'h00, 1'b0, 8'h80, 1);
        chk("first_bit_pos", 0, od_a[0], 8'h80);
        chk("first_bit_pos", 1, od_a[1], 8'h01);
        drain;
        // sparse strobes, then strobes while DONE and IDLE
        frame(8'h96, 1'b1, 8'h00, 3);
        chk("sparse_pre_ov", 0, ov_pre, 0);
        chk("sparse_data", 0, od_a[0], 8'h96);
        chk("sparse_data", 1, od_a[1], 8'h96);
        loop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shift_en = 1'b1; sin = i[0];
            tick;
        end
        shift_en = 1'b0;
        chk("done_hold", 0, od_a[0], 8'h96);
        chk("done_ov", 0, ov_a[0], 1);
        drain;
        shift_en = 1'b1;
        repeat (3) tick;
        shift_en = 1'b0;
        chk("idle_busy", 0, busy_a[0], 0);
        chk("idle_so", 0, so_a[0], 0);
        // backpressure then same-edge handover
        frame(8'h69, 1'b1, 8'h00, 1);
        in_valid = 1'b1; in_data = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_ov", i, ov_a[0], 1);
            chk("bp_ready", i, ir_a[0], 0);
            chk("bp_data", i, od_a[0], 8'h69);
        end
        out_ready = 1'b1;
        #1 chk("bp_comb_ready", 0, ir_a[0], 1);
        tick;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("b2b_ov", 0, ov_a[0], 0);
        chk("b2b_busy", 0, busy_a[0], 1);
        repeat (8) begin
            shift_en = 1'b1;
            tick;
        end
        shift_en = 1'b0;
        chk("b2b_data", 0, od_a[0], 8'hC3);
        chk("b2b_data", 1, od_a[1], 8'hC3);
        drain;
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_xcvr.md
# shift_xcvr

Parameterised full-duplex serial shift transceiver: accepts a parallel word over a valid/ready handshake, shifts it out one bit per `shift_en` strobe while simultaneously capturing `serial_in`, then presents the captured word over a second valid/ready handshake. It is the framed, bidirectional, bit-order-selectable successor to the plain serial shift register in the Shift_Registers group. It sits between a parallel producer/consumer and a serial link or loopback.

## Interface
- `WIDTH`, 8: frame length in bits; legal range WIDTH >= 2.
- `MSB_FIRST`, 1: 1 = transmit/receive MSB first (shift left); 0 = LSB first (shift right).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `shift_en`  in  1  bit strobe; honoured only in SHIFT.
- `in_valid`  in  1  parallel word offered.
- `in_ready`  out  1  word accepted when `in_valid && in_ready`.
- `in_data`  in  WIDTH  word to transmit.
- `serial_in`  in  1  received bit, sampled on each honoured strobe.
- `serial_out`  out  1  registered transmit bit.
- `out_valid`  out  1  captured word available.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_data`  out  WIDTH  captured word, registered.
- `busy`  out  1  high in SHIFT.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). Combinational path out_ready->in_ready is permitted.
- Load (accept on `in_ready`): shift_reg <= in_data; bit count <= 0; serial_out <= first bit (in_data[WIDTH-1] if MSB_FIRST, else in_data[0]); state -> SHIFT.
- SHIFT, `shift_en`=1:
  - MSB_FIRST: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}; serial_out <= shift_reg[WIDTH-2].
  - LSB_FIRST: shift_reg <= {serial_in, shift_reg[WIDTH-1:1]}; serial_out <= shift_reg[1].
  - Count increments. On strobe with count == WIDTH-1 (last bit): out_data <= shifted value including this serial_in; serial_out <= 0; out_valid <= 1; state -> DONE.
- SHIFT, `shift_en`=0: all state held.
- DONE: out_valid=1, out_data stable. On out_ready: out_valid <= 0; if in_valid same cycle, load new word (-> SHIFT), else -> IDLE.
- `shift_en` in IDLE/DONE ignored. `in_valid` while `in_ready`=0 ignored, no effect.
- Loopback (serial_out wired to serial_in) must return out_data == in_data for both bit orders.
- Bit count width: $clog2(WIDTH); no wrap beyond WIDTH-1.

## Timing
- Reset values: serial_out 0, out_valid 0, out_data 0, busy 0, in_ready 1, shift_reg 0, count 0.
- Reset mid-frame: frame discarded immediately (asynchronous); no out_valid for it.
- First bit on serial_out one cycle after load edge.
- Each strobe updates serial_out at that edge; serial_in sampled at the same edge.
- out_valid rises at the edge of the WIDTH-th honoured strobe.
- Shift_en continuous, out_ready held 1, in_valid held 1: frame period WIDTH+1 cycles (load edge + WIDTH strobe edges).
- out_data changes only at frame completion.

## Structure
- Shared package/include `shift_pkg`: state encoding localparams (ST_IDLE, ST_SHIFT, ST_DONE, 2-bit), common `$clog2` count-width helper.
- One sub-module natural: `bit_counter` (parameter WIDTH; clear, enable, last-bit flag), reusable by other shift blocks.
- Datapath (shift_reg, serial_out, out_data) and FSM in top module.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle after 3 strobes -> all outputs at reset values immediately; in_ready 1; next frame 8'h5A loopback returns 8'h5A.
- Loopback, WIDTH=8, MSB_FIRST=1, in_data 8'hA5, shift_en every cycle -> serial_out 1,0,1,0,0,1,0,1; out_valid at 8th strobe edge; out_data 8'hA5; serial_out 0 after.
- Independent capture: in_data 8'hFF, serial_in held 0 -> serial_out 1 for 8 bits; out_data 8'h00. Repeat with in_data 8'h00, serial_in 1 -> out_data 8'hFF.
- MSB_FIRST=0: in_data 8'h01 -> serial_out 1 then seven 0s; loopback of 8'h3C returns 8'h3C; serial_in pattern 1,0,0,0,0,0,0,0 -> out_data 8'h01.
- Sparse strobe: shift_en every 3rd cycle -> exactly 8 honoured strobes, out_valid 3x slower; shift_en pulses in IDLE/DONE change nothing.
- Backpressure/back-to-back: out_ready low 5 cycles in DONE -> out_valid, out_data held, in_ready 0; then out_ready=1 with in_valid=1, in_data 8'hC3 -> same-edge accept, out_valid 0, busy 1, next out_data 8'hC3 in loopback.
